// File: rtl/libhdl_fifo_burst_reader.sv
// libhdl_fifo_burst_reader: drains FIFO words in full or partial bursts onto a valid/ready stream
module libhdl_fifo_burst_reader #(
    parameter int DATA_LEN  = 32,
    parameter int DEPTH     = 1024,
    parameter int BURST_LEN = 16,
    parameter int TIMEOUT   = 256,
    parameter int CNT_LEN   = $clog2(DEPTH + 1),
    parameter int LEN_W     = $clog2(BURST_LEN + 1)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_fifo_vld,
    output logic                o_fifo_rdy,
    input  logic [DATA_LEN-1:0] i_fifo_dat,
    input  logic [CNT_LEN-1:0]  i_fifo_count,
    input  logic                i_flush,
    output logic                o_vld,
    input  logic                i_rdy,
    output logic [DATA_LEN-1:0] o_dat,
    output logic                o_first,
    output logic                o_last,
    output logic [LEN_W-1:0]    o_len,
    output logic                o_busy
);
    localparam int TMO_W = TIMEOUT < 2 ? 1 : $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TIMEOUT == 0 ? '0 : TMO_W'(TIMEOUT - 1);
    localparam logic [CNT_LEN-1:0] FULL_CNT = CNT_LEN'(BURST_LEN);

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] beat;
    logic [TMO_W-1:0] tmo_cnt;
    logic             full, partial, hs, done;

    // state register
    always_ff @(posedge i_clk) begin
        state <= i_rst ? IDLE : state_nxt;
    end

    // next state: full burst wins over flush/timeout, last handshake returns to idle
    always_comb begin
        full      = i_fifo_count >= FULL_CNT;
        partial   = i_fifo_count != '0 && (i_flush || (TIMEOUT != 0 && tmo_cnt == TMO_LAST));
        hs        = state == BURST && i_fifo_vld && i_rdy;
        done      = hs && beat == o_len - LEN_W'(1);
        state_nxt = state == IDLE ? ((full || partial) ? BURST : IDLE) : (done ? IDLE : BURST);
    end

    // outputs: zero-latency pass-through of the FIFO read port while bursting
    always_comb begin
        o_busy     = state == BURST;
        o_vld      = o_busy && i_fifo_vld;
        o_fifo_rdy = o_busy && i_rdy;
        o_dat      = i_fifo_dat;
        o_first    = o_vld && beat == '0;
        o_last     = o_vld && beat == o_len - LEN_W'(1);
    end

    // burst length latch, beat counter and saturating idle timeout counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_len   <= '0;
            beat    <= '0;
            tmo_cnt <= '0;
        end else begin
            if (state == IDLE && full)
                o_len <= LEN_W'(BURST_LEN);
            else if (state == IDLE && partial)
                o_len <= LEN_W'(i_fifo_count);
            beat    <= done ? '0 : (hs ? beat + LEN_W'(1) : beat);
            tmo_cnt <= (state == BURST || i_fifo_count == '0 || full || partial) ? '0 :
                       (tmo_cnt == TMO_LAST ? tmo_cnt : tmo_cnt + TMO_W'(1));
        end
    end
endmodule
